// File: rtl/vram_write_scheduler.sv
// Sole writer of the etch-a-sketch VRAM: runs full-screen clears and stamps a
// square brush around each accepted touch point, one pixel per clock.
module vram_write_scheduler #(
  parameter int          DISPLAY_WIDTH  = 240,
  parameter int          DISPLAY_HEIGHT = 320,
  parameter int          VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter logic [15:0] CLEAR_COLOR    = 16'hFFFF,
  parameter int          BRUSH_R        = 1,
  localparam int         AW             = $clog2(VRAM_L)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  input  logic          touch_valid,
  output logic          touch_ready,
  input  logic [8:0]    touch_x,
  input  logic [8:0]    touch_y,
  input  logic [15:0]   pen_color,
  output logic          busy,
  output logic          clear_done,
  output logic          vram_wr_ena,
  output logic [AW-1:0] vram_wr_addr,
  output logic [15:0]   vram_wr_data
);

  localparam int CW = $clog2(VRAM_L + 1);
  localparam logic signed [3:0] R_POS = 4'(BRUSH_R);
  localparam logic signed [3:0] R_NEG = -R_POS;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_STAMP} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic signed [3:0]  r_dx, r_dy, w_dx_nxt, w_dy_nxt;
  logic               r_ena, r_ready, r_busy, r_done;
  logic               w_ena_nxt, w_ready_nxt, w_busy_nxt, w_done_nxt;
  logic [AW-1:0]      r_addr, w_addr_nxt;
  logic [15:0]        r_data, w_data_nxt;
  logic [8:0]         r_cx, r_cy;
  logic [15:0]        r_color;
  logic               w_latch;

  // Slot generator: selects the pixel that the next posedge would present.
  logic [8:0]         w_bx, w_by;
  logic [15:0]        w_bcol;
  logic signed [3:0]  w_sdx, w_sdy;
  logic signed [10:0] w_px, w_py;
  logic               w_inr, w_last;
  logic [AW-1:0]      w_slot_addr;

  always_comb begin
    w_bx   = touch_x;
    w_by   = touch_y;
    w_bcol = pen_color;
    w_sdx  = R_NEG;
    w_sdy  = R_NEG;
    if (r_state == S_STAMP) begin
      w_bx   = r_cx;
      w_by   = r_cy;
      w_bcol = r_color;
      if (r_dx == R_POS) begin
        w_sdx = R_NEG;
        w_sdy = r_dy + 4'sd1;
      end else begin
        w_sdx = r_dx + 4'sd1;
        w_sdy = r_dy;
      end
    end
  end

  assign w_px   = $signed({2'b00, w_bx}) + $signed({{7{w_sdx[3]}}, w_sdx});
  assign w_py   = $signed({2'b00, w_by}) + $signed({{7{w_sdy[3]}}, w_sdy});
  assign w_inr  = !w_px[10] && !w_py[10] &&
                  (w_px[9:0] < 10'(DISPLAY_WIDTH)) && (w_py[9:0] < 10'(DISPLAY_HEIGHT));
  assign w_slot_addr = AW'(w_py[9:0]) * AW'(DISPLAY_WIDTH) + AW'(w_px[9:0]);
  assign w_last = (r_dx == R_POS) && (r_dy == R_POS);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dx_nxt    = r_dx;
    w_dy_nxt    = r_dy;
    w_ena_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;
    if (clear_req) begin
      // A clear request from any state restarts the sweep with address 0 now.
      w_state_nxt = S_CLEAR;
      w_ena_nxt   = 1'b1;
      w_addr_nxt  = '0;
      w_data_nxt  = CLEAR_COLOR;
      w_cnt_nxt   = CW'(1);
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_cnt == CW'(VRAM_L)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_ena_nxt  = 1'b1;
            w_addr_nxt = AW'(r_cnt);
            w_data_nxt = CLEAR_COLOR;
            w_cnt_nxt  = r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          w_ready_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          if (touch_valid) begin
            w_latch     = 1'b1;
            w_state_nxt = S_STAMP;
            w_ready_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
            w_dx_nxt    = w_sdx;
            w_dy_nxt    = w_sdy;
            w_ena_nxt   = w_inr;
            if (w_inr) begin
              w_addr_nxt = w_slot_addr;
              w_data_nxt = w_bcol;
            end
          end
        end
        S_STAMP: begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_dx_nxt  = w_sdx;
            w_dy_nxt  = w_sdy;
            w_ena_nxt = w_inr;
            if (w_inr) begin
              w_addr_nxt = w_slot_addr;
              w_data_nxt = w_bcol;
            end
          end
        end
        default: w_state_nxt = S_CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_dx    <= R_NEG;
      r_dy    <= R_NEG;
      r_ena   <= 1'b0;
      r_addr  <= '0;
      r_data  <= CLEAR_COLOR;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dx    <= w_dx_nxt;
      r_dy    <= w_dy_nxt;
      r_ena   <= w_ena_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Touch point and colour are pure data; only meaningful once latched.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_cx    <= touch_x;
      r_cy    <= touch_y;
      r_color <= pen_color;
    end
  end

  assign vram_wr_ena  = r_ena;
  assign vram_wr_addr = r_addr;
  assign vram_wr_data = r_data;
  assign touch_ready  = r_ready;
  assign busy         = r_busy;
  assign clear_done   = r_done;

endmodule
